// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch request, memory read port and instruction-register outputs
// of the instruction fetch unit into one interface.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic              flush;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] fetch_pc;
  logic              done;
  logic              pc_inc;
  logic              busy;

  // The fetch unit itself; it owns the memory strobe and the IR.
  modport master (
    input  start, flush, pc_in, mem_rdata,
    output mem_addr, mem_rd_en, ir_out, fetch_pc, done, pc_inc, busy
  );

  // Control unit, PC register and instruction memory side.
  modport slave (
    output start, flush, pc_in, mem_rdata,
    input  mem_addr, mem_rd_en, ir_out, fetch_pc, done, pc_inc, busy
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch engine: samples the PC on request, issues one read to a
// fixed-latency memory, and captures the returned word into the IR.
module instr_fetch_unit #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd_en;
  logic [DATA_W-1:0] r_ir_out;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_done;
  logic              r_pc_inc;
  logic              r_busy;

  logic              w_launch;

  // Flush outranks start, so a simultaneous request never launches.
  assign w_launch = bus.start && !bus.flush;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking '=' would chain them in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
      r_ir_out    <= '0;
      r_fetch_pc  <= '0;
      r_done      <= 1'b0;
      r_pc_inc    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: strobes default low here so each state only has to raise the
      // ones it owns; every output is a register reflecting the next state.
      r_mem_rd_en <= 1'b0;
      r_done      <= 1'b0;
      r_pc_inc    <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_mem_addr  <= bus.pc_in;
            r_mem_rd_en <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_READ;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_READ: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= LP_CNT_INIT;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_ir_out   <= bus.mem_rdata;
            r_fetch_pc <= r_mem_addr;
            r_done     <= 1'b1;
            r_pc_inc   <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.ir_out    = r_ir_out;
  assign bus.fetch_pc  = r_fetch_pc;
  assign bus.done      = r_done;
  assign bus.pc_inc    = r_pc_inc;
  assign bus.busy      = r_busy;

endmodule
